fifo_uart_tx: RTL and testbench

- Downstream consumer of the 16x8 sync FIFO: pops one byte at a time through the FIFO read port and serialises it onto a UART line as 8N1 (or 8N2), LSB first.
- Sits between the FIFO and the board TX pin; the only FIFO-side handshake is rd/empty/dout plus a write-collision flag.
- The FIFO gives writes priority, so a rd in a cycle with an accepted write is silently dropped. This block detects that case and retries the read.

---
 rtl/fifo_uart_tx_pkg.sv | 16 +
 rtl/fifo_uart_tx_if.sv | 26 ++
 rtl/fifo_uart_tx_baud_tick_gen.sv | 27 ++
 rtl/fifo_uart_tx.sv | 112 +++++++++++
 tb/tb_fifo_uart_tx.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

   localparam int DATA_W      = 8;
   localparam int CLK_DIV_DEF = 868;   // 100 MHz / 115200 baud

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      START,
      DATA,
      STOP
   } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake seen by the UART transmitter.
interface fifo_uart_tx_if;
   import fifo_uart_pkg::*;

   logic              fifo_rd;
   logic              fifo_empty;
   logic              fifo_wr_accepted;
   logic [DATA_W-1:0] fifo_dout;

   // Transmitter side: issues reads, observes FIFO status and data.
   modport master (
      output fifo_rd,
      input  fifo_empty,
      input  fifo_wr_accepted,
      input  fifo_dout
   );

   // FIFO side: answers reads.
   modport slave (
      input  fifo_rd,
      output fifo_empty,
      output fifo_wr_accepted,
      output fifo_dout
   );

endinterface

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer: o_tick pulses on the last clk cycle of each bit.
module baud_tick_gen #(
   parameter int CLK_DIV = 868
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   output logic o_tick
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          w_tick;

   assign w_tick = (r_cnt == LAST);
   assign o_tick = w_tick;

   // Count 0..CLK_DIV-1; restart at each bit boundary or while held clear.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)                  r_cnt <= '0;
      else if (i_clear || w_tick)  r_cnt <= '0;
      else                         r_cnt <= r_cnt + CW'(1);
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a write-priority FIFO and sends them as 8N1/8N2 UART
// frames, LSB first. A read lost to a same-cycle FIFO write is retried.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLK_DIV   = CLK_DIV_DEF,
   parameter int STOP_BITS = 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_en,
   fifo_uart_tx_if.master fifo,
   output logic          o_tx,
   output logic          o_busy,
   output logic [15:0]   o_bytes_sent
);

   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   state_t            r_state,      w_state_nxt;
   logic [DATA_W-1:0] r_shift,      w_shift_nxt;
   logic [2:0]        r_bit_idx,    w_bit_idx_nxt;
   logic [15:0]       r_bytes_sent, w_sent_nxt;
   logic              r_tx,         w_tx_nxt;
   logic              r_fifo_rd;
   logic              w_tick;
   logic              w_clear;
   logic              w_start_ok;

   assign w_start_ok   = i_en && !fifo.fifo_empty;
   // Timer only runs while a frame is on the line, so it is at 0 on START entry.
   assign w_clear      = !(r_state inside {START, DATA, STOP});

   assign o_tx         = r_tx;
   assign o_busy       = (r_state != IDLE);
   assign o_bytes_sent = r_bytes_sent;
   assign fifo.fifo_rd = r_fifo_rd;

   baud_tick_gen #(.CLK_DIV(CLK_DIV)) u_baud (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (w_clear),
      .o_tick  (w_tick)
   );

   // Next-state, shift/bit-count and next line level.
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_idx_nxt = r_bit_idx;
      w_sent_nxt    = r_bytes_sent;
      w_tx_nxt      = 1'b1;
      case (r_state)
         IDLE:    if (w_start_ok) w_state_nxt = RD_REQ;
         // Write has priority in the FIFO: a colliding read never happened.
         RD_REQ:  w_state_nxt = fifo.fifo_wr_accepted ? IDLE : RD_WAIT;
         RD_WAIT: begin
            w_shift_nxt = fifo.fifo_dout;
            w_state_nxt = START;
         end
         START: if (w_tick) begin
            w_state_nxt   = DATA;
            w_bit_idx_nxt = 3'd0;
         end
         DATA: if (w_tick) begin
            w_shift_nxt = r_shift >> 1;
            if (r_bit_idx == 3'd7) begin
               w_state_nxt   = STOP;
               w_bit_idx_nxt = 3'd0;
            end else begin
               w_bit_idx_nxt = r_bit_idx + 3'd1;
            end
         end
         STOP: if (w_tick) begin
            if (r_bit_idx == LAST_STOP) begin
               w_sent_nxt    = r_bytes_sent + 16'd1;
               w_bit_idx_nxt = 3'd0;
               w_state_nxt   = w_start_ok ? RD_REQ : IDLE;
            end else begin
               w_bit_idx_nxt = r_bit_idx + 3'd1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // Line level follows the state being entered so tx is a clean flop.
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state      <= IDLE;
         r_shift      <= '0;
         r_bit_idx    <= 3'd0;
         r_bytes_sent <= 16'd0;
         r_tx         <= 1'b1;
         r_fifo_rd    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shift      <= w_shift_nxt;
         r_bit_idx    <= w_bit_idx_nxt;
         r_bytes_sent <= w_sent_nxt;
         r_tx         <= w_tx_nxt;
         r_fifo_rd    <= (w_state_nxt == RD_REQ);
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a UART monitor decodes
// the tx line and compares each received frame against the queue.
module tb_fifo_uart_tx;
   import fifo_uart_pkg::*;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic        tx, busy;
   logic [15:0] bytes_sent;

   // FIFO model (16x8, write priority)
   logic        wr = 1'b0;
   logic [7:0]  din = 8'h00;
   logic [7:0]  mem [16];
   logic [3:0]  wp = 4'd0, rp = 4'd0;
   logic [4:0]  fcnt = 5'd0;
   logic [7:0]  fdout = 8'h00;

   fifo_uart_tx_if fif();

   assign fif.fifo_empty       = (fcnt == 5'd0);
   assign fif.fifo_wr_accepted = wr && (fcnt != 5'd16);
   assign fif.fifo_dout        = fdout;

   always @(posedge clk) begin
      if (wr && fcnt != 5'd16) begin
         mem[wp] <= din;
         wp      <= wp + 4'd1;
         fcnt    <= fcnt + 5'd1;
      end else if (fif.fifo_rd && fcnt != 5'd0) begin
         fdout   <= mem[rp];
         rp      <= rp + 4'd1;
         fcnt    <= fcnt - 5'd1;
      end
   end

   fifo_uart_tx #(.CLK_DIV(DIV), .STOP_BITS(1)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (en),
      .fifo         (fif.master),
      .o_tx         (tx),
      .o_busy       (busy),
      .o_bytes_sent (bytes_sent)
   );

   initial forever #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_q[$];
   logic [15:0] exp_sent = 16'd0;
   int          starts[$];
   int          rd_cnt = 0;
   int          cyc = 0;
   logic        mon_active = 1'b0;
   int          mon_cnt = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // Monitor: UART receiver sampling mid-bit on negedges, plus rd pulse rules.
   initial begin
      logic [7:0] rx;
      logic       prev_rd;
      rx = 8'h00;
      prev_rd = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            mon_active = 1'b0;
            prev_rd    = 1'b0;
         end else begin
            if (fif.fifo_rd === 1'b1) begin
               rd_cnt++;
               check("rd_not_back_to_back", {31'd0, prev_rd}, 32'd0);
            end
            prev_rd = fif.fifo_rd;
            if (!mon_active) begin
               if (tx === 1'b0) begin
                  mon_active = 1'b1;
                  mon_cnt    = 0;
                  starts.push_back(cyc);
               end
            end else begin
               mon_cnt++;
            end
            if (mon_active) begin
               if (mon_cnt == 2)
                  check("start_bit_low", {31'd0, tx}, 32'd0);
               else if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 2) % 4) == 0)
                  rx[(mon_cnt - 6) / 4] = tx;
               else if (mon_cnt == 38) begin
                  check("stop_bit_high", {31'd0, tx}, 32'd1);
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_errors++;
                     $display("FAIL unexpected_frame: got %0h expected none", rx);
                  end else begin
                     check("frame_data", {24'd0, rx}, {24'd0, exp_q.pop_front()});
                  end
                  mon_active = 1'b0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      tick();
      wr  = 1'b1;
      din = b;
      tick();
      wr  = 1'b0;
   endtask

   task automatic expect_byte(input logic [7:0] b);
      exp_q.push_back(b);
      exp_sent = exp_sent + 16'd1;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: got busy=%0b pending=%0d expected idle", name, busy, exp_q.size());
      end
   endtask

   task automatic wait_mon(input int c, input string name);
      int n;
      n = 0;
      while (!(mon_active && mon_cnt == c) && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: got cnt=%0d expected %0d", name, mon_cnt, c);
      end
   endtask

   initial begin
      int rd0;
      // Reset state
      #12;
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rd", {31'd0, fif.fifo_rd}, 32'd0);
      check("rst_bytes", {16'd0, bytes_sent}, 32'd0);
      tick();
      rst = 1'b1;
      tick();

      // Single byte 0xA5, with start latency
      rd0 = rd_cnt;
      push_byte(8'hA5);
      expect_byte(8'hA5);
      en = 1'b1;
      tick();
      check("lat_rd_cycle1", {31'd0, fif.fifo_rd}, 32'd1);
      tick();
      check("lat_rd_cycle2", {31'd0, fif.fifo_rd}, 32'd0);
      check("lat_tx_cycle2", {31'd0, tx}, 32'd1);
      tick();
      check("lat_tx_cycle3", {31'd0, tx}, 32'd0);
      wait_done("single");
      check("single_rd_pulses", rd_cnt - rd0, 32'd1);
      check("single_bytes", {16'd0, bytes_sent}, {16'd0, exp_sent});
      check("single_busy_low", {31'd0, busy}, 32'd0);

      // Back-to-back frames
      en = 1'b0;
      push_byte(8'h00);
      push_byte(8'hFF);
      push_byte(8'h3C);
      expect_byte(8'h00);
      expect_byte(8'hFF);
      expect_byte(8'h3C);
      starts.delete();
      en = 1'b1;
      wait_done("b2b");
      check("b2b_frames", starts.size(), 32'd3);
      if (starts.size() == 3) begin
         check("b2b_gap01", starts[1] - starts[0], 32'd42);
         check("b2b_gap12", starts[2] - starts[1], 32'd42);
      end
      check("b2b_bytes", {16'd0, bytes_sent}, {16'd0, exp_sent});

      // Read collision: write lands in the RD_REQ cycle
      en = 1'b0;
      push_byte(8'h5A);
      rd0 = rd_cnt;
      expect_byte(8'h5A);
      expect_byte(8'h77);
      tick();
      en = 1'b1;
      tick();
      check("coll_rd_req", {31'd0, fif.fifo_rd}, 32'd1);
      wr  = 1'b1;
      din = 8'h77;
      tick();
      wr  = 1'b0;
      check("coll_back_idle", {31'd0, busy}, 32'd0);
      wait_done("coll");
      check("coll_rd_pulses", rd_cnt - rd0, 32'd3);
      check("coll_bytes", {16'd0, bytes_sent}, {16'd0, exp_sent});

      // Enable gating mid-frame
      en = 1'b0;
      push_byte(8'h11);
      push_byte(8'h22);
      rd0 = rd_cnt;
      expect_byte(8'h11);
      en = 1'b1;
      wait_mon(18, "gate");
      en = 1'b0;
      wait_done("gate");
      repeat (20) tick();
      check("gate_rd_pulses", rd_cnt - rd0, 32'd1);
      check("gate_fifo_cnt", {27'd0, fcnt}, 32'd1);
      check("gate_bytes", {16'd0, bytes_sent}, {16'd0, exp_sent});
      expect_byte(8'h22);
      en = 1'b1;
      wait_done("gate2");
      check("gate2_rd_pulses", rd_cnt - rd0, 32'd2);
      check("gate2_fifo_cnt", {27'd0, fcnt}, 32'd0);

      // Reset mid-frame
      en = 1'b0;
      push_byte(8'h99);
      en = 1'b1;
      wait_mon(10, "rstmid");
      rst = 1'b0;
      exp_sent = 16'd0;
      #1;
      check("rstmid_tx", {31'd0, tx}, 32'd1);
      check("rstmid_busy", {31'd0, busy}, 32'd0);
      check("rstmid_bytes", {16'd0, bytes_sent}, 32'd0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      rd0 = rd_cnt;
      repeat (20) tick();
      check("rstmid_no_rd", rd_cnt - rd0, 32'd0);
      check("rstmid_idle", {31'd0, busy}, 32'd0);
      en = 1'b0;
      push_byte(8'h42);
      expect_byte(8'h42);
      en = 1'b1;
      wait_done("rstmid2");
      check("rstmid2_bytes", {16'd0, bytes_sent}, {16'd0, exp_sent});

      // Counter wrap
      en = 1'b0;
      tick();
      force dut.r_bytes_sent = 16'hFFFF;
      tick();
      release dut.r_bytes_sent;
      tick();
      check("wrap_preload", {16'd0, bytes_sent}, 32'h0000FFFF);
      exp_sent = 16'hFFFF;
      push_byte(8'h0F);
      expect_byte(8'h0F);
      en = 1'b1;
      wait_done("wrap");
      check("wrap_bytes", {16'd0, bytes_sent}, {16'd0, exp_sent});
      check("wrap_zero", {16'd0, bytes_sent}, 32'd0);

      repeat (10) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
